// File: rtl/cbu_master_pkg.sv
// Shared definitions for the cache bus unit: FSM states, one-hot bus sizes
// and the fixed beat width of the L1/bus data path.
package cbu_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WT,
    S_RD,
    S_LINE,
    S_DONE
  } state_e;

  localparam logic [3:0] SIZE_B = 4'b0001;
  localparam logic [3:0] SIZE_H = 4'b0010;
  localparam logic [3:0] SIZE_W = 4'b0100;
  localparam logic [3:0] SIZE_D = 4'b1000;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned BEAT_SH    = $clog2(BEAT_BYTES);

endpackage

// File: rtl/cbu_watchdog.sv
// Bus ack watchdog: counts cycles with en high and no clr, and flags expire
// in the TIMEOUT_CYCLES-th such cycle. Only used when CBU_TIMEOUT_EN is set.
module cbu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cbu_master.sv
// Cache bus unit: turns L1 write-through, single-read and line-refill
// requests into single-beat bus transactions. Optional watchdog: CBU_TIMEOUT_EN.
module cbu_master
  import cbu_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned LINE_BEATS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              L1_write_through_req,
  input  logic              read_req,
  input  logic              read_line_req,
  input  logic [3:0]        L1_size,
  input  logic [ADDR_W-1:0] pa,
  input  logic [DATA_W-1:0] wt_data,
  output logic [DATA_W-1:0] line_data,
  output logic [10:0]       addr_count,
  output logic              line_write,
  output logic              cache_entry_write,
  output logic              trans_rdy,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_size,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned OFF_W  = $clog2(LINE_BEATS * BEAT_BYTES);
  localparam int unsigned BEAT_W = $clog2(LINE_BEATS);

  if (LINE_BEATS < 2 || LINE_BEATS > 256 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("cbu_master: LINE_BEATS must be 2..256 and TIMEOUT_CYCLES >= 2");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pa_q, pa_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   line_data_q, line_data_d;
  logic [10:0]         addr_count_q, addr_count_d;
  logic                line_write_q, line_write_d;
  logic                entry_write_q, entry_write_d;
  logic                trans_rdy_q, trans_rdy_d;
  logic                bus_error_q, bus_error_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_size_q, bus_size_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic                ack_v;
  logic                timeout;
  logic                bus_clr;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [ADDR_W-1:0]   line_base_in;
  logic [ADDR_W-1:0]   line_base_cap;

  // Acks are only meaningful while a transaction is being presented.
  assign ack_v         = bus_ack && bus_req_q;
  assign beat_nxt      = beat_q + BEAT_W'(1);
  assign line_base_in  = {pa[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign line_base_cap = {pa_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef CBU_TIMEOUT_EN
  cbu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (bus_req_q),
    .clr    (ack_v),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pa_d          = pa_q;
    beat_d        = beat_q;
    line_data_d   = line_data_q;
    addr_count_d  = addr_count_q;
    line_write_d  = 1'b0;
    entry_write_d = 1'b0;
    trans_rdy_d   = 1'b0;
    bus_error_d   = 1'b0;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_size_d    = bus_size_q;
    bus_wdata_d   = bus_wdata_q;
    bus_clr       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (L1_write_through_req || read_line_req || read_req) begin
          pa_d        = pa;
          beat_d      = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = pa;
          bus_size_d  = L1_size;
          bus_wdata_d = '0;
          if (L1_write_through_req) begin
            state_d     = S_WT;
            bus_we_d    = 1'b1;
            bus_wdata_d = wt_data;
          end else if (read_line_req) begin
            state_d    = S_LINE;
            bus_addr_d = line_base_in;
            bus_size_d = SIZE_D;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_WT, S_RD: begin
        if (ack_v) begin
          state_d     = S_DONE;
          bus_clr     = 1'b1;
          trans_rdy_d = 1'b1;
          bus_error_d = bus_err;
          if (state_q == S_RD && !bus_err) begin
            line_write_d = 1'b1;
            line_data_d  = bus_rdata;
            addr_count_d = 11'(pa_q[OFF_W-1:0]);
          end
        end else if (timeout) begin
          state_d     = S_DONE;
          bus_clr     = 1'b1;
          trans_rdy_d = 1'b1;
          bus_error_d = 1'b1;
        end
      end

      S_LINE: begin
        if (ack_v && bus_err) begin
          state_d     = S_DONE;
          bus_clr     = 1'b1;
          trans_rdy_d = 1'b1;
          bus_error_d = 1'b1;
        end else if (ack_v) begin
          line_write_d = 1'b1;
          line_data_d  = bus_rdata;
          addr_count_d = 11'(beat_q) << BEAT_SH;
          if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
            state_d       = S_DONE;
            bus_clr       = 1'b1;
            trans_rdy_d   = 1'b1;
            entry_write_d = 1'b1;
          end else begin
            // Next beat address is presented right away so bus_req never drops.
            beat_d     = beat_nxt;
            bus_addr_d = line_base_cap | (ADDR_W'(beat_nxt) << BEAT_SH);
          end
        end else if (timeout) begin
          state_d     = S_DONE;
          bus_clr     = 1'b1;
          trans_rdy_d = 1'b1;
          bus_error_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
        bus_clr = 1'b1;
      end
    endcase

    if (bus_clr) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = '0;
      bus_size_d  = '0;
      bus_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pa_q          <= '0;
      beat_q        <= '0;
      line_data_q   <= '0;
      addr_count_q  <= '0;
      line_write_q  <= 1'b0;
      entry_write_q <= 1'b0;
      trans_rdy_q   <= 1'b0;
      bus_error_q   <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_size_q    <= '0;
      bus_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      pa_q          <= pa_d;
      beat_q        <= beat_d;
      line_data_q   <= line_data_d;
      addr_count_q  <= addr_count_d;
      line_write_q  <= line_write_d;
      entry_write_q <= entry_write_d;
      trans_rdy_q   <= trans_rdy_d;
      bus_error_q   <= bus_error_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_size_q    <= bus_size_d;
      bus_wdata_q   <= bus_wdata_d;
    end
  end

  assign line_data         = line_data_q;
  assign addr_count        = addr_count_q;
  assign line_write        = line_write_q;
  assign cache_entry_write = entry_write_q;
  assign trans_rdy         = trans_rdy_q;
  assign bus_error         = bus_error_q;
  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_addr          = bus_addr_q;
  assign bus_size          = bus_size_q;
  assign bus_wdata         = bus_wdata_q;

endmodule

// File: tb/tb_cbu_master.sv
// Directed bench for cbu_master: read, line refill, write-through, line error,
// request priority, mid-line reset and (with CBU_TIMEOUT_EN) the watchdog.
module tb_cbu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        L1_write_through_req, read_req, read_line_req;
  logic [3:0]  L1_size;
  logic [31:0] pa;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_write, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_size;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int pulses;
  int edges;

  cbu_master #(
    .ADDR_W        (32),
    .DATA_W        (64),
    .LINE_BEATS    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .L1_write_through_req (L1_write_through_req),
    .read_req             (read_req),
    .read_line_req        (read_line_req),
    .L1_size              (L1_size),
    .pa                   (pa),
    .wt_data              (wt_data),
    .line_data            (line_data),
    .addr_count           (addr_count),
    .line_write           (line_write),
    .cache_entry_write    (cache_entry_write),
    .trans_rdy            (trans_rdy),
    .bus_error            (bus_error),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_size             (bus_size),
    .bus_wdata            (bus_wdata),
    .bus_ack              (bus_ack),
    .bus_rdata            (bus_rdata),
    .bus_err              (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".bus_req"}, 64'(bus_req), 64'd0);
    chk({tag, ".bus_we"}, 64'(bus_we), 64'd0);
    chk({tag, ".bus_addr"}, 64'(bus_addr), 64'd0);
    chk({tag, ".bus_size"}, 64'(bus_size), 64'd0);
    chk({tag, ".bus_wdata"}, bus_wdata, 64'd0);
    chk({tag, ".line_write"}, 64'(line_write), 64'd0);
    chk({tag, ".entry"}, 64'(cache_entry_write), 64'd0);
    chk({tag, ".trans_rdy"}, 64'(trans_rdy), 64'd0);
    chk({tag, ".bus_error"}, 64'(bus_error), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    L1_write_through_req = 1'b0;
    read_req = 1'b0;
    read_line_req = 1'b0;
    L1_size = 4'b0000;
    pa = '0;
    wt_data = '0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    bus_err = 1'b0;
    step();
    step();
    chk_quiet("reset");
    chk("reset.line_data", line_data, 64'd0);
    chk("reset.addr_count", 64'(addr_count), 64'd0);
    rst = 1'b0;
    step();

    // Single read: ack in the first bus cycle.
    read_req = 1'b1; pa = 32'h8000_0014; L1_size = 4'b0100;
    step();
    chk("rd.bus_req", 64'(bus_req), 64'd1);
    chk("rd.bus_we", 64'(bus_we), 64'd0);
    chk("rd.bus_addr", 64'(bus_addr), 64'h8000_0014);
    chk("rd.bus_size", 64'(bus_size), 64'b0100);
    bus_ack = 1'b1; bus_rdata = 64'h1122_3344_5566_7788;
    step();
    chk("rd.trans_rdy", 64'(trans_rdy), 64'd1);
    chk("rd.line_write", 64'(line_write), 64'd1);
    chk("rd.line_data", line_data, 64'h1122_3344_5566_7788);
    chk("rd.addr_count", 64'(addr_count), 64'h14);
    chk("rd.entry", 64'(cache_entry_write), 64'd0);
    chk("rd.bus_error", 64'(bus_error), 64'd0);
    chk("rd.bus_req_done", 64'(bus_req), 64'd0);
    bus_ack = 1'b0; read_req = 1'b0;
    step();
    chk_quiet("rd.after");

    // Line refill with zero-wait acks.
    read_line_req = 1'b1; pa = 32'h8000_0048; L1_size = 4'b0001;
    step();
    edges = 1;
    chk("line.bus_addr0", 64'(bus_addr), 64'h8000_0040);
    chk("line.bus_size", 64'(bus_size), 64'b1000);
    chk("line.bus_req", 64'(bus_req), 64'd1);
    read_line_req = 1'b0; bus_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bus_rdata = 64'hA5A5_0000_0000_0000 | 64'(i * 17);
      step();
      edges++;
      if (line_write) pulses++;
      chk("line.line_data", line_data, 64'hA5A5_0000_0000_0000 | 64'(i * 17));
      chk("line.addr_count", 64'(addr_count), 64'(i * 8));
      if (i < 7) begin
        chk("line.next_addr", 64'(bus_addr), 64'h8000_0040 + 64'((i + 1) * 8));
        chk("line.req_held", 64'(bus_req), 64'd1);
        chk("line.no_rdy", 64'(trans_rdy), 64'd0);
      end
    end
    chk("line.pulses", 64'(pulses), 64'd8);
    chk("line.trans_rdy", 64'(trans_rdy), 64'd1);
    chk("line.entry", 64'(cache_entry_write), 64'd1);
    chk("line.bus_error", 64'(bus_error), 64'd0);
    chk("line.req_drop", 64'(bus_req), 64'd0);
    // Request cycle + 8 bus cycles + DONE cycle = LINE_BEATS+2 cycles: 9 edges.
    chk("line.latency", 64'(edges), 64'd9);
    bus_ack = 1'b0;
    step();
    chk_quiet("line.after");

    // Write-through with three wait cycles; inputs change mid-transaction.
    L1_write_through_req = 1'b1; pa = 32'h0000_0100; wt_data = 64'hDEAD; L1_size = 4'b0010;
    step();
    pa = 32'hFFFF_FFF0; wt_data = 64'hBEEF; L1_size = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      chk("wt.bus_req", 64'(bus_req), 64'd1);
      chk("wt.bus_we", 64'(bus_we), 64'd1);
      chk("wt.bus_wdata", bus_wdata, 64'hDEAD);
      chk("wt.bus_addr", 64'(bus_addr), 64'h100);
      chk("wt.bus_size", 64'(bus_size), 64'b0010);
      chk("wt.no_rdy", 64'(trans_rdy), 64'd0);
      if (k == 3) bus_ack = 1'b1;
      step();
    end
    chk("wt.trans_rdy", 64'(trans_rdy), 64'd1);
    chk("wt.bus_error", 64'(bus_error), 64'd0);
    chk("wt.line_write", 64'(line_write), 64'd0);
    chk("wt.entry", 64'(cache_entry_write), 64'd0);
    bus_ack = 1'b0; L1_write_through_req = 1'b0;
    step();
    chk_quiet("wt.after");

    // Line refill, error response on beat index 3.
    read_line_req = 1'b1; pa = 32'h0000_0200;
    step();
    read_line_req = 1'b0; bus_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 64'(i + 100);
      bus_err = (i == 3);
      if (i == 3) chk("lerr.beat3_addr", 64'(bus_addr), 64'h218);
      step();
      if (line_write) pulses++;
    end
    chk("lerr.pulses", 64'(pulses), 64'd3);
    chk("lerr.trans_rdy", 64'(trans_rdy), 64'd1);
    chk("lerr.bus_error", 64'(bus_error), 64'd1);
    chk("lerr.entry", 64'(cache_entry_write), 64'd0);
    chk("lerr.req_drop", 64'(bus_req), 64'd0);
    bus_ack = 1'b0; bus_err = 1'b0;
    step();
    chk_quiet("lerr.no_beat4");

    // Ack while idle must be ignored.
    bus_ack = 1'b1;
    step();
    chk("idle_ack.line_write", 64'(line_write), 64'd0);
    chk("idle_ack.trans_rdy", 64'(trans_rdy), 64'd0);
    bus_ack = 1'b0;

    // All three requests: write-through first, then line over read.
    L1_write_through_req = 1'b1; read_line_req = 1'b1; read_req = 1'b1;
    pa = 32'h0000_0300; wt_data = 64'h55; L1_size = 4'b1000;
    step();
    chk("prio.wt_we", 64'(bus_we), 64'd1);
    chk("prio.wt_addr", 64'(bus_addr), 64'h300);
    bus_ack = 1'b1;
    step();
    chk("prio.wt_rdy", 64'(trans_rdy), 64'd1);
    bus_ack = 1'b0; L1_write_through_req = 1'b0;
    step();
    chk("prio.done_ignores", 64'(bus_req), 64'd0);
    step();
    chk("prio.line_we", 64'(bus_we), 64'd0);
    chk("prio.line_size", 64'(bus_size), 64'b1000);
    chk("prio.line_req", 64'(bus_req), 64'd1);
    read_line_req = 1'b0; read_req = 1'b0; bus_ack = 1'b1;
    step();
    step();
    chk("prio.mid_addr", 64'(bus_addr), 64'h310);
    bus_ack = 1'b0; rst = 1'b1;
    step();
    chk_quiet("midrst");
    rst = 1'b0;
    step();
    chk_quiet("midrst.idle");

`ifdef CBU_TIMEOUT_EN
    read_req = 1'b1; pa = 32'h40; L1_size = 4'b0100;
    step();
    read_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("to.req_high", 64'(bus_req), 64'd1);
      step();
    end
    chk("to.req_drop", 64'(bus_req), 64'd0);
    chk("to.trans_rdy", 64'(trans_rdy), 64'd1);
    chk("to.bus_error", 64'(bus_error), 64'd1);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbu_master.md
Name: cbu_master

Overview:
- Cache bus unit that sits directly downstream of the L1/BIU cell.
- Accepts the L1 miss/uncached requests: write-through, single read and line refill.
- Converts each request into single-beat transactions on the system bus.
- Returns data, beat offsets, the entry-update strobe and completion/error status to L1.

Parameters:
ADDR_W, 32, physical address width (matches pa).
DATA_W, 64, data width of L1 and bus.
LINE_BEATS, 8, beats per cache line (power of 2, 2..256).
TIMEOUT_CYCLES, 1024, ack wait limit (used only with optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
L1_write_through_req  in  1  write-through request (level, held until trans_rdy)
read_req  in  1  single uncached read request (level)
read_line_req  in  1  line refill request (level)
L1_size  in  4  one-hot size: 0001=1B, 0010=2B, 0100=4B, 1000=8B
pa  in  ADDR_W  physical address
wt_data  in  DATA_W  write-through data
line_data  out  DATA_W  read data of current beat
addr_count  out  11  byte offset within line of current beat
line_write  out  1  one-cycle strobe: line_data/addr_count valid
cache_entry_write  out  1  one-cycle strobe: line fully filled, update tag
trans_rdy  out  1  one-cycle strobe: request finished
bus_error  out  1  one-cycle strobe with trans_rdy: request failed
bus_req  out  1  bus request valid
bus_we  out  1  1=write
bus_addr  out  ADDR_W  bus address
bus_size  out  4  one-hot size
bus_wdata  out  DATA_W  write data
bus_ack  in  1  transaction accepted and completed this cycle
bus_rdata  in  DATA_W  read data, valid with bus_ack
bus_err  in  1  error response, valid with bus_ack

Behaviour:
- Reset: all outputs 0, FSM IDLE, beat counter 0. Reset mid-transaction abandons it in the same edge (bus_req low next cycle); no strobes are issued.
- States: IDLE, WT, RD, LINE, DONE.
- IDLE: priority is L1_write_through_req > read_line_req > read_req. Capture pa, L1_size and wt_data into registers, then go to WT, LINE or RD respectively.
- WT/RD: bus_req=1, bus_addr=captured pa, bus_size=captured size, bus_we=1 for WT. On bus_ack go to DONE.
  - RD additionally loads line_data=bus_rdata and pulses line_write, with addr_count = pa byte offset within line.
- LINE:
  - Base = pa with low log2(LINE_BEATS*8) bits cleared; bus_addr = base + beat*8; bus_size=1000.
  - Each bus_ack with bus_err=0: pulse line_write, line_data=bus_rdata, addr_count=beat*8, beat increments.
  - Last beat ack: go to DONE with the entry flag set.
  - bus_req stays high between beats; the next beat address is presented the cycle after the ack.
- Any bus_ack with bus_err=1: no line_write that cycle; remaining beats aborted; go to DONE with error flag.
- DONE (exactly one cycle): trans_rdy=1; bus_error=error flag; cache_entry_write=1 only if LINE completed without error. Then IDLE. Requests seen in DONE are ignored; L1 must drop its request the cycle after trans_rdy.
- Minimum latency: request sampled at edge N, bus_req in cycle N+1, ack at N+1 gives trans_rdy in N+2. A full line with zero-wait acks takes LINE_BEATS+2 cycles.
- bus_ack while bus_req=0: ignored.
- Captured registers are stable for the whole transaction; input changes mid-transaction are ignored.

Optional Feature:
- Macro: CBU_TIMEOUT_EN.
- Defined: a watchdog counts cycles with bus_req=1 and no bus_ack, cleared on each ack. At TIMEOUT_CYCLES it deasserts bus_req and goes to DONE with bus_error=1.
- Undefined: waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package/header: FSM state encodings, one-hot size constants (SIZE_B/H/W/D), beat byte width (8).
- One sub-module, cbu_watchdog: timeout counter with clear/enable/expire, instantiated only under CBU_TIMEOUT_EN.

Test Plan:
- read_req, pa=0x8000_0014, size=0100; ack next cycle with rdata=0x1122334455667788 -> bus_addr=0x80000014, size=0100, line_write with addr_count=0x14, trans_rdy one cycle later, no cache_entry_write.
- read_line_req, pa=0x8000_0048, zero-wait acks -> 8 beats at 0x80000040..0x78, addr_count 0..56 step 8, cache_entry_write and trans_rdy together in cycle 10 after the request.
- Write-through pa=0x100, wt_data=0xDEAD, size=0010, ack after 3 wait cycles -> bus_we=1 and bus_wdata held for all 4 cycles, single trans_rdy, bus_error=0.
- Line refill with bus_err on beat 3 -> 3 line_write pulses only, bus_error and trans_rdy pulse, no cache_entry_write, beat 4 never issued.
- All three requests asserted together -> write-through served first; then rst asserted mid-line -> outputs 0 next cycle, FSM IDLE.
- CBU_TIMEOUT_EN with TIMEOUT_CYCLES=16, bus_ack never asserted -> bus_req drops after 16 cycles, bus_error and trans_rdy pulse together.
